alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU between two requesters, e.g. an issue port and an address/utility port.
- Arbitrates round-robin and holds the ALU inputs stable for an op-dependent number of cycles, so MUL and DIV can close timing as multicycle paths.
- Registers the result with a valid/ready response channel.
- Drives the ALU input ports and samples its result and zero flag; it does not contain the ALU.

Parameters:
- MUL_CYCLES, 2, cycles ALU inputs held for MUL (op 4'b0111); legal range 1-15.
- DIV_CYCLES, 8, cycles ALU inputs held for DIV (op 4'b1100); legal range 1-15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_op  in  4  ALU opcode.
- req0_a  in  32  operand1.
- req0_b  in  32  operand2.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- alu_op  out  4  to ALU op.
- alu_a  out  32  to ALU operand1.
- alu_b  out  32  to ALU operand2.
- alu_result  in  32  from ALU result.
- alu_zero  in  1  from ALU zero_flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_result  out  32  registered result.
- rsp_zero  out  1  registered zero flag.
- rsp_id  out  1  requester that issued the operation.
- rsp_err  out  1  illegal opcode, or DIV with operand2 == 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - FSM = IDLE, rr_last = 1 (so req0 wins the first tie).
  - Outputs rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err = 0.
  - alu_op = 4'b1111, alu_a = alu_b = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational. It is high only in IDLE, for exactly one granted valid requester.
  - If only one request is valid, grant it. If both are valid, grant the requester that is not rr_last.
  - On grant, capture op/a/b, rsp_id = N and rr_last = N.
  - Load cnt = latency-1:
    - latency = 1 for AND 0000, OR 0001, XOR 0010, ADD 0101, SUB 0110, and for any illegal op;
    - latency = MUL_CYCLES for MUL;
    - latency = DIV_CYCLES for DIV.
  - Go to EXEC.
- EXEC:
  - alu_op/alu_a/alu_b are driven from the captured registers and held constant for the whole state.
  - If cnt != 0, decrement cnt.
  - If cnt == 0:
    - capture rsp_result = alu_result and rsp_zero = alu_zero;
    - for an illegal op, set rsp_err = 1;
    - for DIV with b == 0, force rsp_result = 0, rsp_zero = 1 and rsp_err = 1. The ALU output is ignored in this case.
    - Go to RESP.
- Outside EXEC: alu_op = 4'b1111 and operands = 0. The ALU then outputs 0, which prevents spurious toggling.
- RESP:
  - rsp_valid = 1, and all rsp_* fields are stable until the handshake.
  - When rsp_ready is high, go to IDLE; rsp_valid drops next cycle.
  - No new grant is made in the handshake cycle. The earliest re-grant is the following cycle.
- Latency: with latency 1, a request accepted at cycle T has rsp_valid at T+2. In general, rsp_valid is at T+1+latency.
- Requesters must hold reqN_* stable while valid and not ready. A valid request may wait any number of cycles.
- Back-to-back arbitration: alternation is guaranteed when both requesters are continuously valid.
- Reset asserted mid-EXEC or mid-RESP:
  - immediately return to the reset values;
  - the in-flight operation is discarded and no response is issued.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined:
  - adds outputs grant_cnt0 and grant_cnt1 (out, 16 bits each), counting grants per requester;
  - both counters saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single ADD: req0 ADD a=5 b=7 at T → req0_ready at T, alu_op=0101 at T+1, rsp_valid at T+2 with result=12, zero=0, id=0, err=0.
- Tie alternation: req0 and req1 both held valid with SUB 9-9 → grants go req0, req1, req0 (rr_last reset = 1). Each response has result=0, zero=1, and rsp_id alternates.
- Multicycle DIV: req1 DIV 100/7, DIV_CYCLES=8 → alu_a/b/op held stable for 8 cycles, rsp_valid at T+9, result=14. A req0 arriving during EXEC is not granted until after the handshake.
- Errors:
  - DIV 5/0 → result=0, zero=1, err=1;
  - op 4'b1000 → result=0, err=1, latency 1.
- Backpressure: rsp_ready low for 5 cycles → rsp_* stable and no req_ready asserted; rsp_ready high → IDLE next cycle, and a pending request is granted the cycle after.
- Reset mid-MUL: rst_n low during EXEC → all outputs at reset values asynchronously and no rsp_valid afterwards. With ALU_ARB_STATS_EN, grant_cnt0/1 read 0 after reset and count 3/2 after 3 req0 and 2 req1 grants.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 32-bit ALU between two requesters.
// Holds ALU inputs for op-dependent cycles; optional ALU_ARB_STATS_EN grant counters.
module alu_arbiter #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_id,
    output logic        rsp_err
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
`endif
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1100;
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_nx;
    logic        rr_last;
    logic [3:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        grant0;
    logic        grant1;
    logic [3:0]  op_sel;
    logic [31:0] a_sel;
    logic [31:0] b_sel;

    function automatic logic [3:0] lat_m1(input logic [3:0] op);
        case (op)
            OP_MUL:  return 4'(MUL_CYCLES - 1);
            OP_DIV:  return 4'(DIV_CYCLES - 1);
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic illegal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_ADD,
            OP_SUB, OP_MUL, OP_DIV: return 1'b0;
            default:                return 1'b1;
        endcase
    endfunction

    assign op_sel = grant1 ? req1_op : req0_op;
    assign a_sel  = grant1 ? req1_a  : req0_a;
    assign b_sel  = grant1 ? req1_b  : req0_b;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Grant, next state and ALU/response drive; ALU idles at NOP outside EXEC
    always_comb begin
        state_nx   = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        alu_op     = OP_NOP;
        alu_a      = 32'd0;
        alu_b      = 32'd0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                grant0 = req0_valid && (!req1_valid || rr_last);
                grant1 = req1_valid && (!req0_valid || !rr_last);
                if (grant0 || grant1) state_nx = EXEC;
            end
            EXEC: begin
                alu_op = op_q;
                alu_a  = a_q;
                alu_b  = b_q;
                if (cnt == 4'd0) state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        req0_ready = grant0;
        req1_ready = grant1;
    end

    // Operation capture, hold counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last    <= 1'b1;
            cnt        <= 4'd0;
            op_q       <= OP_NOP;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            rsp_result <= 32'd0;
            rsp_zero   <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (grant0 || grant1) begin
            op_q    <= op_sel;
            a_q     <= a_sel;
            b_q     <= b_sel;
            rsp_id  <= grant1;
            rr_last <= grant1;
            cnt     <= lat_m1(op_sel);
        end else if (state == EXEC) begin
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else if (op_q == OP_DIV && b_q == 32'd0) begin
                rsp_result <= 32'd0;
                rsp_zero   <= 1'b1;
                rsp_err    <= 1'b1;
            end else begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_err    <= illegal(op_q);
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Saturating per-requester grant counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else begin
            if (grant0 && grant_cnt0 != 16'hFFFF)
                grant_cnt0 <= grant_cnt0 + 16'd1;
            if (grant1 && grant_cnt1 != 16'hFFFF)
                grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule
